// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// mode_t: 2-bit shift-mode encoding carried on in_mode and through every stage.
package barrel_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline level of the barrel shifter: a combinational shift by 2^K
// (when remaining-shamt bit K is set) followed by the payload register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en                global advance; all stages load together
//   in_valid/out_valid   beat-present bit
//   in_data/out_data     operand / partially shifted operand
//   in_shamt/out_shamt   full shift amount (each stage consumes bit K)
//   in_mode/out_mode     shift mode (barrel_pkg::mode_t encoding)
//   in_sign/out_sign     original operand MSB, used as SRA fill
//   out_zero             registered out_data == 0
module barrel_shift_stage
  import barrel_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned K       = 0,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic               in_sign,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [1:0]         out_mode,
  output logic               out_sign,
  output logic               out_zero
);

  localparam int unsigned STEP = 1 << K;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] shifted;

  // SRA fills from the carried sign rather than the current MSB, since an
  // earlier rotate/shift stage never runs for SRA beats but the bit must be
  // the original operand MSB regardless of stage order.
  always_comb begin
    shifted = in_data;
    if (in_shamt[K]) begin
      case (mode_t'(in_mode))
        MODE_SLL: shifted = in_data << STEP;
        MODE_SRL: shifted = in_data >> STEP;
        MODE_SRA: shifted = (in_data >> STEP) | (in_sign ? ~(ALL_ONES >> STEP) : '0);
        MODE_ROL: shifted = (in_data << STEP) | (in_data >> (WIDTH - STEP));
        default:  shifted = in_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_mode  <= '0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b1;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_shamt <= in_shamt;
      out_mode  <= in_mode;
      out_sign  <= in_sign;
      out_zero  <= (shifted == '0);
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA / ROL, one mux level per
// shift-amount bit, each registered; one result per clock under a
// valid/ready handshake with a single global advance signal.
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid, in_ready    input handshake (in_ready = adv, combinational)
//   in_data, in_shamt     operand and shift amount 0..WIDTH-1
//   in_mode               00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid, out_ready  output handshake
//   out_data, out_zero    result and registered result==0 flag
module pipelined_barrel_shifter
  import barrel_pkg::*;
#(
  parameter  int unsigned WIDTH   = 16,
  localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_zero
);

  logic               adv;
  logic [SHAMT_W:0]   valid;
  logic [WIDTH-1:0]   data  [SHAMT_W+1];
  logic [SHAMT_W-1:0] shamt [SHAMT_W+1];
  logic [1:0]         mode  [SHAMT_W+1];
  logic [SHAMT_W:0]   sign;
  logic [SHAMT_W:1]   zero;

  // The whole pipe moves as one: it may advance whenever the final slot is
  // empty or being drained, so bubbles never block and nothing is dropped.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  assign valid[0] = in_valid;
  assign data[0]  = in_data;
  assign shamt[0] = in_shamt;
  assign mode[0]  = in_mode;
  assign sign[0]  = in_data[WIDTH-1];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH  (WIDTH),
      .K      (k),
      .SHAMT_W(SHAMT_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .in_valid (valid[k]),
      .in_data  (data[k]),
      .in_shamt (shamt[k]),
      .in_mode  (mode[k]),
      .in_sign  (sign[k]),
      .out_valid(valid[k+1]),
      .out_data (data[k+1]),
      .out_shamt(shamt[k+1]),
      .out_mode (mode[k+1]),
      .out_sign (sign[k+1]),
      .out_zero (zero[k+1])
    );
  end

  assign out_valid = valid[SHAMT_W];
  assign out_data  = data[SHAMT_W];
  assign out_zero  = zero[SHAMT_W];

  // Payload that the last stage carries but nothing downstream consumes.
  logic unused_tail;
  assign unused_tail = ^{shamt[SHAMT_W], mode[SHAMT_W], sign[SHAMT_W], zero[SHAMT_W-1:1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=16): directed
// scenarios plus randomized traffic against a bit-level reference model.
module tb_pipelined_barrel_shifter;

  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] got[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           last_stall = -100;
  int           n_acc = 0;
  int           last_acc = 0;
  bit           prev_hold = 0;
  logic [W-1:0] prev_data;
  logic         prev_zero;
  logic         ov_hist [0:8191];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-by-bit definition of each mode: where does output bit i come from.
  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input int s, input logic [1:0] m);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'b00:   r[i] = (i >= s) ? d[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < W) ? d[i+s] : 1'b0;
        2'b10:   r[i] = (i + s < W) ? d[i+s] : d[W-1];
        default: r[i] = d[(i - s + W) % W];
      endcase
    end
    return r;
  endfunction

  // Compare process: everything sampled at the falling edge, when inputs
  // and registered outputs are stable.
  always @(negedge clk) begin
    cyc++;
    ov_hist[cyc % 8192] = out_valid;
    if (rst) begin
      prev_hold = 0;
    end else begin
      chk("in_ready", in_ready, out_ready || !out_valid);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_zero", out_zero, prev_zero);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("data", out_data, q[0].data);
          chk("zero", out_zero, q[0].data == '0);
          if (last_stall < q[0].cyc) chk("latency", cyc - q[0].cyc, SW);
          if (out_ready) begin
            got.push_back(out_data);
            void'(q.pop_front());
          end
        end
      end
      if (out_valid && !out_ready) last_stall = cyc;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_zero = out_zero;
      if (in_valid && in_ready) begin
        q.push_back('{model_shift(in_data, int'(in_shamt), in_mode), cyc});
        n_acc++;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int s, input logic [1:0] m);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SW'(s);
    in_mode  = m;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] bp_d [6];
  int           c1, c2;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = 2'b00; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_zero", out_zero, 1);
    #9 rst = 1'b0;

    // Pin the model to hand-computed results.
    chk("pin_sll", model_shift(16'd128, 4, 2'b00), 16'd2048);
    chk("pin_sll7", model_shift(16'd255, 7, 2'b00), 16'd32640);
    chk("pin_srl", model_shift(16'h8000, 15, 2'b01), 16'h0001);
    chk("pin_sra", model_shift(16'h8000, 3, 2'b10), 16'hF000);
    chk("pin_rol", model_shift(16'h8001, 1, 2'b11), 16'h0003);
    chk("pin_srl1", model_shift(16'h0001, 1, 2'b01), 16'h0000);
    chk("pin_sra_pos", model_shift(16'h4000, 14, 2'b10), 16'h0001);

    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single SLL beat.
    got.delete();
    send(16'd128, 4, 2'b00);
    drain();
    chk("t1_count", got.size(), 1);
    chk("t1_value", got[0], 16'd2048);

    // Back-to-back, one mode each.
    got.delete();
    send(16'd255, 7, 2'b00);
    send(16'h8000, 15, 2'b01);
    send(16'h8000, 3, 2'b10);
    send(16'h8001, 1, 2'b11);
    drain();
    chk("t2_count", got.size(), 4);
    chk("t2_r0", got[0], 16'd32640);
    chk("t2_r1", got[1], 16'h0001);
    chk("t2_r2", got[2], 16'hF000);
    chk("t2_r3", got[3], 16'h0003);

    // Zero shift in every mode, and out_zero both ways.
    got.delete();
    for (int m = 0; m < 4; m++) send(16'hA5C3, 0, 2'(m));
    send(16'h0001, 0, 2'b00);
    send(16'h0001, 1, 2'b01);
    drain();
    chk("t3_count", got.size(), 6);
    for (int m = 0; m < 4; m++) chk("t3_identity", got[m], 16'hA5C3);
    chk("t3_nonzero", got[4], 16'h0001);
    chk("t3_zero", got[5], 16'h0000);

    // Backpressure: pipe fills after 4 beats and the head holds.
    got.delete();
    for (int i = 0; i < 6; i++) bp_d[i] = W'($urandom);
    out_ready = 1'b0;
    c1 = n_acc;
    fork
      for (int i = 0; i < 6; i++) send(bp_d[i], i + 1, 2'(i % 4));
    join_none
    repeat (10) @(negedge clk);
    chk("bp_accepted", n_acc - c1, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, model_shift(bp_d[0], 1, 2'b00));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait fork;
    drain();
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_order", got[i], model_shift(bp_d[i], i + 1, 2'(i % 4)));

    // Bubbles: in_valid 1,0,1,0.
    send(16'h1234, 2, 2'b11);
    c1 = last_acc;
    @(posedge clk); #1;
    send(16'h00F0, 4, 2'b01);
    c2 = last_acc;
    @(posedge clk); #1;
    drain();
    chk("bubble_gap", c2 - c1, 2);
    chk("bubble_ov0", ov_hist[(c1 + 4) % 8192], 1);
    chk("bubble_ov1", ov_hist[(c1 + 5) % 8192], 0);
    chk("bubble_ov2", ov_hist[(c1 + 6) % 8192], 1);
    chk("bubble_ov3", ov_hist[(c1 + 7) % 8192], 0);

    // Reset with beats in flight, asserted between clock edges.
    send(16'h0F0F, 1, 2'b00);
    send(16'hFFFF, 3, 2'b10);
    send(16'h1111, 5, 2'b11);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_zero", out_zero, 1);
    q.delete();
    prev_hold = 0;
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_quiet", out_valid, 0);
    @(posedge clk); #1;
    got.delete();
    send(16'h0003, 14, 2'b00);
    drain();
    chk("post_rst_count", got.size(), 1);
    chk("post_rst_value", got[0], 16'hC000);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_shamt  = SW'($urandom_range(0, W - 1));
      in_mode   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
